cron_bcd_param: RTL and testbench

- Parametrised successor to the 0-999 stopwatch. Counts in BCD over DIGITS digits, up or down, with load, clear and a run/stop toggle.
- In down mode it acts as a countdown timer that halts at zero.
- Sits between the board clock and the 7-segment display driver. The internal tick generator replaces the fixed 1 Hz divider.

---
 rtl/cron_pkg.sv | 56 +++++
 rtl/divisor_tick.sv | 43 ++++
 rtl/cron_bcd_param.sv | 174 +++++++++++++++++
 tb/tb_cron_bcd_param.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cron_pkg.sv
// rtl/cron_pkg.sv - shared types, constants and BCD digit helpers for cron_bcd_param
//
// Purpose: FSM state enum, BCD nibble type, digit constants, per-digit
//          increment/decrement with carry/borrow, and a constant-time
//          integer-to-BCD converter used to build the terminal count.
// Ports:   none (package).
package cron_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cron_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Returns {carry_out, digit}. With cin=0 the digit passes through untouched.
  function automatic logic [4:0] bcd_inc_digit(input bcd_digit_t d, input logic cin);
    if (!cin) begin
      return {1'b0, d};
    end else if (d >= BCD_MAX) begin
      return {1'b1, BCD_ZERO};
    end else begin
      return {1'b0, d + 4'd1};
    end
  endfunction

  // Returns {borrow_out, digit}. With bin=0 the digit passes through untouched.
  function automatic logic [4:0] bcd_dec_digit(input bcd_digit_t d, input logic bin);
    if (!bin) begin
      return {1'b0, d};
    end else if (d == BCD_ZERO) begin
      return {1'b1, BCD_MAX};
    end else begin
      return {1'b0, d - 4'd1};
    end
  endfunction

  // Elaboration-time only: turns the decimal MAX_COUNT parameter into BCD
  // so the runtime datapath never touches a binary count.
  function automatic logic [63:0] int_to_bcd(input int unsigned value);
    logic [63:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// rtl/divisor_tick.sv - parametrised prescaler with registered one-cycle tick
//
// Purpose: counts 0..DIV-1 while enabled, holding its value while disabled so
//          a pause/resume loses no phase. tick is high for the cycle in which
//          the counter sits at its terminal value.
// Ports:   clk    - system clock
//          rst    - synchronous reset, active-high
//          enable - advance the counter on this edge
//          clear  - force counter to 0 and drop tick
//          tick   - registered terminal-count pulse
module divisor_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM     = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE_TERM = CW'(DIV - 2);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (enable) begin
      r_cnt  <= (r_cnt == TERM) ? '0 : r_cnt + 1'b1;
      // Registered so tick coincides with the counter holding TERM.
      r_tick <= (r_cnt == PRE_TERM);
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/cron_bcd_param.sv
// rtl/cron_bcd_param.sv - parametrised BCD up/down stopwatch and countdown timer
//
// Purpose: counts in BCD over DIGITS digits at TICK_HZ, up (wrapping after
//          MAX_COUNT) or down (halting at zero in DONE), with clear, load and a
//          run/stop toggle. Optional lap capture under CRON_LAP_CAPTURE_EN.
// Ports:   clk, rst          - clock, synchronous active-high reset
//          start_stop        - pulse, toggles run/stop
//          clear             - pulse, count and prescaler to 0
//          load, load_val    - pulse, preset count (nibbles saturated to 9)
//          dir               - 0 up, 1 down, sampled on each tick
//          lap               - pulse, snapshot count into lap_q
//          q, lap_q          - current and captured BCD count
//          running           - high in RUN
//          tick              - prescaler pulse (RUN only)
//          wrap              - pulse on up-mode terminal -> 0
//          done              - level, countdown reached zero
module cron_bcd_param
  import cron_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 1,
  parameter int DIGITS    = 3,
  parameter int MAX_COUNT = 999
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                dir,
  input  logic                lap,
  output logic [4*DIGITS-1:0] q,
  output logic [4*DIGITS-1:0] lap_q,
  output logic                running,
  output logic                tick,
  output logic                wrap,
  output logic                done
);

  localparam int W   = 4 * DIGITS;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam logic [63:0]  MAX_BCD64 = int_to_bcd(MAX_COUNT);
  localparam logic [W-1:0] MAX_BCD   = MAX_BCD64[W-1:0];
  localparam logic [W-1:0] BCD_ONE   = W'(1);

  cron_state_t r_state, w_state_next;
  logic [W-1:0] r_q, w_q_next;
  logic         r_wrap, w_wrap_next;
  logic         w_tick, w_count_en, w_presc_en;

  logic [DIGITS:0] w_inc_c, w_dec_b;
  logic [W-1:0]    w_inc, w_dec, w_load_sat;

  assign w_inc_c[0] = 1'b1;
  assign w_dec_b[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [4:0] w_inc_res, w_dec_res;
    assign w_inc_res          = bcd_inc_digit(r_q[4*g +: 4], w_inc_c[g]);
    assign w_dec_res          = bcd_dec_digit(r_q[4*g +: 4], w_dec_b[g]);
    assign w_inc_c[g+1]       = w_inc_res[4];
    assign w_dec_b[g+1]       = w_dec_res[4];
    assign w_inc[4*g +: 4]    = w_inc_res[3:0];
    assign w_dec[4*g +: 4]    = w_dec_res[3:0];
    assign w_load_sat[4*g +: 4] = (load_val[4*g +: 4] > BCD_MAX) ? BCD_MAX : load_val[4*g +: 4];
  end

  // Top-digit carry/borrow is superseded by the explicit wrap and zero checks.
  logic [1:0] w_unused_carry;
  assign w_unused_carry = {w_inc_c[DIGITS], w_dec_b[DIGITS]};

  // Prescaler advances on edges whose following state is RUN, so tick can
  // only be high while r_state is RUN and resumes exactly where it paused.
  assign w_presc_en = (w_state_next == RUN);

  divisor_tick #(
    .DIV(DIV)
  ) u_divisor_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(w_presc_en),
    .clear (clear),
    .tick  (w_tick)
  );

  // clear and load both discard a coincident tick.
  assign w_count_en = w_tick && (r_state == RUN) && !clear && !load;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      STOP: begin
        if (start_stop) w_state_next = RUN;
      end
      RUN: begin
        if (start_stop) begin
          w_state_next = STOP;
        end else if (w_count_en && dir && ((r_q == '0) || (r_q == BCD_ONE))) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        // Restart only makes sense with something left to count down.
        if (start_stop && !clear && (load ? (w_load_sat != '0) : (r_q != '0))) begin
          w_state_next = RUN;
        end else if (clear || load) begin
          w_state_next = STOP;
        end
      end
      default: w_state_next = STOP;
    endcase
  end

  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    if (clear) begin
      w_q_next = '0;
    end else if (load) begin
      w_q_next = w_load_sat;
    end else if (w_count_en) begin
      if (!dir) begin
        // >= also catches loaded values above the terminal count.
        if (r_q >= MAX_BCD) begin
          w_q_next    = '0;
          w_wrap_next = 1'b1;
        end else begin
          w_q_next = w_inc;
        end
      end else if (r_q != '0) begin
        w_q_next = w_dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STOP;
      r_q     <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_wrap  <= w_wrap_next;
    end
  end

`ifdef CRON_LAP_CAPTURE_EN
  logic [W-1:0] r_lap_q;

  // Captures r_q before any same-edge tick update.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_lap_q <= '0;
    end else if (lap) begin
      r_lap_q <= r_q;
    end
  end

  assign lap_q = r_lap_q;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign lap_q        = '0;
`endif

  assign q       = r_q;
  assign tick    = w_tick;
  assign wrap    = r_wrap;
  assign running = (r_state == RUN);
  assign done    = (r_state == DONE);

endmodule

// File: tb/tb_cron_bcd_param.sv
// tb/tb_cron_bcd_param.sv - directed self-checking bench for cron_bcd_param
module tb_cron_bcd_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load_val = '0;
  logic        dir = 1'b0;
  logic        lap = 1'b0;
  logic [11:0] q, lap_q;
  logic        running, tick, wrap, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cron_bcd_param #(
    .CLK_HZ(10), .TICK_HZ(1), .DIGITS(3), .MAX_COUNT(999)
  ) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
    .load(load), .load_val(load_val), .dir(dir), .lap(lap),
    .q(q), .lap_q(lap_q), .running(running), .tick(tick),
    .wrap(wrap), .done(done)
  );

  // Pulse helpers: called just after a negedge, return just after the next one.
  task automatic do_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic do_load(input logic [11:0] v);
    load = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({q, lap_q} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_q: q=%h lap_q=%h expected 000 000", q, lap_q);
    end
    n_tests++;
    if ({running, tick, wrap, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: run/tick/wrap/done=%b expected 0000", {running, tick, wrap, done});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_up_count();
    int ticks;
    ticks = 0;
    dir = 1'b0;
    do_clear();
    do_ss();
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    n_tests++;
    if (q !== 12'h010) begin
      n_fail++;
      $display("FAIL up_q: q=%h expected 010", q);
    end
    n_tests++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL up_running: running=%b expected 1", running);
    end
    n_tests++;
    if (ticks != 10) begin
      n_fail++;
      $display("FAIL up_ticks: ticks=%0d expected 10", ticks);
    end
    do_ss();
    n_tests++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL up_stop: running=%b expected 0", running);
    end
  endtask

  task automatic test_wrap();
    int wraps, idx;
    logic [11:0] q_at_wrap;
    wraps = 0;
    idx = -1;
    q_at_wrap = 12'hFFF;
    do_clear();
    do_load(12'h998);
    dir = 1'b0;
    do_ss();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (wrap) begin
        wraps++;
        idx = i;
        q_at_wrap = q;
      end
    end
    n_tests++;
    if (wraps != 1 || idx != 19) begin
      n_fail++;
      $display("FAIL wrap_pulse: count=%0d at=%0d expected 1 at 19", wraps, idx);
    end
    n_tests++;
    if (q_at_wrap !== 12'h000) begin
      n_fail++;
      $display("FAIL wrap_q: q=%h expected 000", q_at_wrap);
    end
    do_ss();
  endtask

  task automatic test_countdown();
    logic saw_one;
    int   at;
    saw_one = 1'b0;
    at = -1;
    do_clear();
    do_load(12'h002);
    dir = 1'b1;
    do_ss();
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (q === 12'h001) saw_one = 1'b1;
      if (done === 1'b1) begin
        at = i;
        break;
      end
    end
    n_tests++;
    if (!saw_one || at != 19) begin
      n_fail++;
      $display("FAIL down_seq: saw_001=%b done_at=%0d expected 1 at 19", saw_one, at);
    end
    n_tests++;
    if ({q, running, done} !== {12'h000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL down_done: q=%h running=%b done=%b expected 000 0 1", q, running, done);
    end
    do_ss();
    @(negedge clk);
    n_tests++;
    if ({running, done} !== 2'b01) begin
      n_fail++;
      $display("FAIL down_restart_zero: running=%b done=%b expected 0 1", running, done);
    end
    do_load(12'h000);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL down_load_exit: done=%b expected 0", done);
    end
    dir = 1'b0;
  endtask

  task automatic test_pause();
    int first;
    logic stray;
    first = -1;
    stray = 1'b0;
    do_clear();
    dir = 1'b0;
    do_ss();
    repeat (2) @(negedge clk);
    do_ss();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tick) stray = 1'b1;
    end
    n_tests++;
    if (running !== 1'b0 || stray) begin
      n_fail++;
      $display("FAIL pause_hold: running=%b tick_seen=%b expected 0 0", running, stray);
    end
    do_ss();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (tick && first < 0) first = i;
    end
    n_tests++;
    if (first != 5) begin
      n_fail++;
      $display("FAIL pause_phase: first_tick=%0d expected 5", first);
    end
    do_ss();
  endtask

  task automatic test_priority();
    do_clear();
    do_load(12'h123);
    clear = 1'b1;
    start_stop = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start_stop = 1'b0;
    n_tests++;
    if ({q, running} !== {12'h000, 1'b1}) begin
      n_fail++;
      $display("FAIL prio_clear_ss: q=%h running=%b expected 000 1", q, running);
    end
    do_load(12'h0F5);
    n_tests++;
    if ({q, running} !== {12'h095, 1'b1}) begin
      n_fail++;
      $display("FAIL prio_load_sat: q=%h running=%b expected 095 1", q, running);
    end
    do_ss();
  endtask

  task automatic test_load_tick();
    logic seen;
    seen = 1'b0;
    do_clear();
    do_load(12'h050);
    dir = 1'b0;
    do_ss();
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (tick) seen = 1'b1;
    end
    do_load(12'h300);
    @(negedge clk);
    n_tests++;
    if (!seen || q !== 12'h300) begin
      n_fail++;
      $display("FAIL load_tick: tick_seen=%b q=%h expected 1 300", seen, q);
    end
    do_ss();
  endtask

  task automatic test_borrow();
    logic seen;
    seen = 1'b0;
    do_clear();
    do_load(12'h100);
    dir = 1'b1;
    do_ss();
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (tick) seen = 1'b1;
    end
    @(negedge clk);
    n_tests++;
    if (!seen || q !== 12'h099) begin
      n_fail++;
      $display("FAIL borrow: tick_seen=%b q=%h expected 1 099", seen, q);
    end
    do_ss();
    dir = 1'b0;
  endtask

  task automatic test_lap();
    logic seen;
    logic [11:0] exp_lap;
`ifdef CRON_LAP_CAPTURE_EN
    exp_lap = 12'h041;
`else
    exp_lap = 12'h000;
`endif
    seen = 1'b0;
    do_clear();
    do_load(12'h041);
    dir = 1'b0;
    do_ss();
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (tick) seen = 1'b1;
    end
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    n_tests++;
    if (!seen || q !== 12'h042) begin
      n_fail++;
      $display("FAIL lap_q_step: tick_seen=%b q=%h expected 1 042", seen, q);
    end
    n_tests++;
    if (lap_q !== exp_lap) begin
      n_fail++;
      $display("FAIL lap_capture: lap_q=%h expected %h", lap_q, exp_lap);
    end
    do_clear();
    n_tests++;
    if (lap_q !== 12'h000) begin
      n_fail++;
      $display("FAIL lap_clear: lap_q=%h expected 000", lap_q);
    end
    do_ss();
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_wrap();
    test_countdown();
    test_pause();
    test_priority();
    test_load_tick();
    test_borrow();
    test_lap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
